// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU operation codes and arbiter FSM states.
// Optional statistics are enabled with ALU_ARB_STATS_EN.
package alu_arbiter_pkg;

  localparam int MAX_ALU_REQ = 4;

  typedef enum logic [3:0] {
    Add                    = 4'd0,
    Subtract               = 4'd1,
    Shift_Left_Logical     = 4'd2,
    Shift_Right_Logical    = 4'd3,
    Shift_Right_Arithmetic = 4'd4,
    Bitwise_And            = 4'd5,
    Bitwise_Or             = 4'd6,
    Bitwise_Xor            = 4'd7,
    Set_Less_Than          = 4'd8,
    Set_Less_Than_Unsigned = 4'd9
  } alu_operation_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXECUTE = 2'd1,
    RESPOND = 2'd2
  } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single-cycle combinational ALU shared by all arbiter requesters.
// Undefined operation codes produce a zero result.
module alu
  import alu_arbiter_pkg::*;
(
  input  alu_operation_t operation,
  input  logic [31:0]    operand_1,
  input  logic [31:0]    operand_2,
  output logic [31:0]    result
);

  logic [4:0] shamt;
  assign shamt = operand_2[4:0];

  always_comb begin
    result = '0;
    case (operation)
      Add:
        result = operand_1 + operand_2;
      Subtract:
        result = operand_1 - operand_2;
      Shift_Left_Logical:
        result = operand_1 << shamt;
      Shift_Right_Logical:
        result = operand_1 >> shamt;
      Shift_Right_Arithmetic:
        result = $signed(operand_1) >>> shamt;
      Bitwise_And:
        result = operand_1 & operand_2;
      Bitwise_Or:
        result = operand_1 | operand_2;
      Bitwise_Xor:
        result = operand_1 ^ operand_2;
      Set_Less_Than:
        result = {31'd0,
          $signed(operand_1) < $signed(operand_2)};
      Set_Less_Than_Unsigned:
        result = {31'd0, operand_1 < operand_2};
      default:
        result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// Define ALU_ARB_STATS_EN to add per-requester saturating grant counters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  alu_operation_t [NUM_REQ-1:0] req_operation,
  input  logic [NUM_REQ-1:0][31:0]    req_operand_1,
  input  logic [NUM_REQ-1:0][31:0]    req_operand_2,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [31:0]                 rsp_result,
  output logic                        busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]    grant_count
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  alu_arb_state_t   state_q, state_d;
  logic [PTR_W-1:0] last_q, last_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  alu_operation_t   op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      res_q, res_d;
  logic [31:0]      alu_res;
  logic [PTR_W:0]   pick;
  logic [PTR_W-1:0] win;

  // MSB flags a winner; scan starts just after the last granted requester.
  function automatic logic [PTR_W:0] rr_pick(
    logic [NUM_REQ-1:0] v,
    logic [PTR_W-1:0]   last
  );
    logic [PTR_W:0] r;
    int             j;
    r = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % NUM_REQ;
      if (v[PTR_W'(j)])
        r = {1'b1, PTR_W'(j)};
    end
    return r;
  endfunction

  assign pick = rr_pick(req_valid, last_q);
  assign win  = pick[PTR_W-1:0];

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gidx_d    = gidx_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (pick[PTR_W] && !reset) begin
          req_ready[win] = 1'b1;
          gidx_d  = win;
          op_d    = req_operation[win];
          a_d     = req_operand_1[win];
          b_d     = req_operand_2[win];
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        res_d   = alu_res;
        state_d = RESPOND;
      end
      RESPOND: begin
        if (rsp_ready[gidx_q]) begin
          last_d  = gidx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= PTR_W'(NUM_REQ - 1);
      gidx_q  <= '0;
      op_q    <= Add;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  alu u_alu (
    .operation (op_q),
    .operand_1 (a_q),
    .operand_2 (b_q),
    .result    (alu_res)
  );

  assign rsp_valid  = (state_q == RESPOND)
                    ? (NUM_REQ'(1) << gidx_q) : '0;
  assign rsp_result = res_q;
  assign busy       = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && req_valid[i]
            && cnt_q[i] != 16'hFFFF)
          cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule
